// File: rtl/tdm_demux.sv
// ----------------------------------------------------------------------------
// tdm_demux
// Receive end of a 4:1 time-multiplexed bus. Beats carry one WIDTH-bit slot
// value tagged with a 2-bit slot index. Slots 0..3 must arrive in order; slots
// 0..2 are staged internally and the frame is published on the slot-3 beat,
// so partial frames never reach the outputs. Completion is reported with a
// valid/ack handshake; sequencing errors and unacknowledged overwrites are
// reported as single-cycle pulses.
//
// Ports
//   i_clk           system clock, all state changes on rising edge
//   i_rst           synchronous reset, active-high
//   i_din           slot data
//   i_din_sel       slot index of i_din (0..3)
//   i_din_valid     i_din/i_din_sel sampled this cycle when high
//   i_frame_ack     consumer accepts the presented frame
//   o_y0..o_y3      assembled frame slots 0..3 (registered)
//   o_frame_valid   high while an unacknowledged frame is on o_y0..o_y3
//   o_framing_err   1-cycle pulse: out-of-order slot received
//   o_overrun       1-cycle pulse: frame overwritten before ack
// ----------------------------------------------------------------------------
module tdm_demux #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_din,
    input  logic [1:0]       i_din_sel,
    input  logic             i_din_valid,
    input  logic             i_frame_ack,
    output logic [WIDTH-1:0] o_y0,
    output logic [WIDTH-1:0] o_y1,
    output logic [WIDTH-1:0] o_y2,
    output logic [WIDTH-1:0] o_y3,
    output logic             o_frame_valid,
    output logic             o_framing_err,
    output logic             o_overrun
);

    // Expected-slot states: the state value is the slot index accepted next.
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    logic [1:0]       r_exp;
    logic [WIDTH-1:0] r_stage0;
    logic [WIDTH-1:0] r_stage1;
    logic [WIDTH-1:0] r_stage2;
    logic [WIDTH-1:0] r_y0;
    logic [WIDTH-1:0] r_y1;
    logic [WIDTH-1:0] r_y2;
    logic [WIDTH-1:0] r_y3;
    logic             r_frame_valid;
    logic             r_framing_err;
    logic             r_overrun;

    logic w_in_order;
    logic w_out_of_order;
    logic w_complete;

    // Beat classification against the expected slot.
    always_comb begin
        w_in_order     = 1'b0;
        w_out_of_order = 1'b0;
        w_complete     = 1'b0;
        if (i_din_valid) begin
            w_in_order     = (i_din_sel == r_exp);
            w_out_of_order = (i_din_sel != r_exp);
            w_complete     = (i_din_sel == r_exp) && (r_exp == S3);
        end else begin
            w_in_order     = 1'b0;
            w_out_of_order = 1'b0;
            w_complete     = 1'b0;
        end
    end

    // Slot sequencer and staging registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exp    <= S0;
            r_stage0 <= {WIDTH{1'b0}};
            r_stage1 <= {WIDTH{1'b0}};
            r_stage2 <= {WIDTH{1'b0}};
        end else if (w_in_order) begin
            case (r_exp)
                S0: begin
                    r_stage0 <= i_din;
                    r_exp    <= S1;
                end
                S1: begin
                    r_stage1 <= i_din;
                    r_exp    <= S2;
                end
                S2: begin
                    r_stage2 <= i_din;
                    r_exp    <= S3;
                end
                S3:      r_exp <= S0;
                default: r_exp <= S0;
            endcase
        end else if (w_out_of_order) begin
            // A stray slot 0 is taken as the start of a new frame; any other
            // stray slot drops the beat and waits for slot 0. Staging of the
            // later slots is left as-is since it is rewritten before use.
            if (i_din_sel == S0) begin
                r_stage0 <= i_din;
                r_exp    <= S1;
            end else begin
                r_exp    <= S0;
            end
        end else begin
            r_exp <= r_exp;
        end
    end

    // Frame publication, handshake and status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_y0          <= {WIDTH{1'b0}};
            r_y1          <= {WIDTH{1'b0}};
            r_y2          <= {WIDTH{1'b0}};
            r_y3          <= {WIDTH{1'b0}};
            r_frame_valid <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_framing_err <= w_out_of_order;
            // An ack arriving with the completing beat consumes the old frame,
            // so only an unacknowledged pending frame counts as overrun.
            r_overrun     <= w_complete && r_frame_valid && !i_frame_ack;
            if (w_complete) begin
                r_y0          <= r_stage0;
                r_y1          <= r_stage1;
                r_y2          <= r_stage2;
                r_y3          <= i_din;
                r_frame_valid <= 1'b1;
            end else if (i_frame_ack) begin
                r_frame_valid <= 1'b0;
            end else begin
                r_frame_valid <= r_frame_valid;
            end
        end
    end

    assign o_y0          = r_y0;
    assign o_y1          = r_y1;
    assign o_y2          = r_y2;
    assign o_y3          = r_y3;
    assign o_frame_valid = r_frame_valid;
    assign o_framing_err = r_framing_err;
    assign o_overrun     = r_overrun;

endmodule
